pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Generates per-stage enable and flush/bubble controls plus EX-operand forwarding selects.
//  - Handles load-use stalls, taken-branch flushes and multi-cycle data-memory wait states.
//  - Halts the pipeline on a memory timeout. Sits beside the datapath, fed by stage register fields.
// PARAMETERS
//  REG_ADDR_W   5    register-file address width
//  MEM_TIMEOUT  16   max consecutive MEM_WAIT cycles before the pipeline halts
//  CNT_W        16   width of the timeout counter and the perf counters
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           asynchronous reset, active-low (asserted when 0)
//  id_rs, id_rt   in   REG_ADDR_W  ID-stage source registers
//  id_use_rs/rt   in   1           ID instruction reads rs / rt
//  ex_rs, ex_rt   in   REG_ADDR_W  EX-stage source registers (forwarding)
//  ex_rd          in   REG_ADDR_W  EX-stage destination
//  ex_mem_read    in   1           EX instruction is a load
//  ex_branch_taken in  1           branch resolved taken in EX
//  mem_rd, wb_rd  in   REG_ADDR_W  destinations in MEM / WB
//  mem_reg_write, wb_reg_write in 1  RF write enables in MEM / WB
//  mem_req        in   1           MEM stage accesses data memory
//  mem_ready      in   1           data memory completes this cycle
//  pc_en          out  1           PC update enable
//  pr1_en, pr1_flush out 1         IF/ID hold / clear
//  pr2_en, pr2_flush out 1         ID/EX hold / insert bubble
//  pr3_en         out  1           EX/MEM hold
//  pr4_bubble     out  1           force MEM/WB write_en=0 on load
//  fwd_a, fwd_b   out  2           00 RF, 01 from EX/MEM alu_out, 10 from MEM/WB write data
//  halted         out  1           sticky; set on timeout
// BEHAVIOUR
//  - Reset values: state=RUN; counter=0; halted=0.
//  - Enables and flushes are combinational from state and inputs.
//  - Outputs under reset: all enables=1, flushes=0, pr4_bubble=0, fwd=00.
//  - States: RUN, MEM_WAIT, HALT.
//    - RUN->MEM_WAIT when mem_req&&!mem_ready.
//    - MEM_WAIT->RUN when mem_ready.
//    - MEM_WAIT->HALT when counter==MEM_TIMEOUT-1 && !mem_ready.
//    - HALT is left only by reset.
//  - Counter: cleared in RUN; +1 per MEM_WAIT cycle.
//  - Priority 1, mem stall (mem_req&&!mem_ready, any state) or HALT:
//    - pc_en=pr1_en=pr2_en=pr3_en=0, pr4_bubble=1, all flushes=0.
//    - Branch and load-use evaluation are suppressed; EX is frozen, so branch_taken persists.
//  - Priority 2, ex_branch_taken: pr1_flush=1, pr2_flush=1, all enables=1.
//  - Priority 3, load-use: ex_mem_read && ex_rd!=0 && ((id_use_rs&&ex_rd==id_rs)||(id_use_rt&&ex_rd==id_rt)).
//    - pc_en=0, pr1_en=0, pr2_flush=1 for exactly one cycle.
//  - Release is zero latency: mem_ready=1 re-enables all stages in the same cycle.
//  - Forwarding:
//    - fwd_a=01 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs.
//    - Else fwd_a=10 on the same test with wb_* fields.
//    - Else fwd_a=00. fwd_b uses ex_rt. EX/MEM wins over MEM/WB.
//    - Forwarding is computed in all states.
//  - Reset mid-stall returns to RUN immediately and clears halted.
// CONFIGURATION
//  - PIPE_PERF_CNT_EN defined: adds outputs stall_cycles, flush_events (CNT_W each).
//    - stall_cycles counts cycles with pc_en=0.
//    - flush_events counts cycles with pr1_flush=1.
//    - Both saturate at all-ones and reset to 0.
//  - Undefined: the ports do not exist and no counter logic is built.
// STRUCTURE
//  - Shared package hazard_pkg: state enum, fwd_sel_t (FWD_RF/FWD_MEM/FWD_WB) and REG_ADDR_W default.
//  - One sub-module, hazard_fwd_unit: purely combinational forwarding for one operand, instantiated twice.
// TESTING
//  - Load r3 in EX, ID reads r3: pc_en=0, pr1_en=0, pr2_flush=1 for 1 cycle, then normal.
//  - Same case with ex_rd=0: no stall.
//  - Branch taken with load-use also true: pr1_flush=pr2_flush=1, pc_en=1.
//  - mem_req=1, mem_ready=0 for 3 cycles, then 1:
//    - pc/pr1-3 enables held 0 and pr4_bubble=1 for 3 cycles.
//    - All enables return to 1 in the mem_ready cycle.
//  - mem_ready held 0 for 16 cycles: halted=1 from cycle 17.
//    - Enables stay 0 after mem_ready=1; rst=0 clears halted.
//  - mem_rd=wb_rd=ex_rs=5, both writes set: fwd_a=01.
//    - With mem_reg_write=0: fwd_a=10.
//    - With mem_rd=wb_rd=0: fwd_a=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and default widths for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned DEF_REG_ADDR_W  = 5;
   localparam int unsigned DEF_MEM_TIMEOUT = 16;
   localparam int unsigned DEF_CNT_W       = 16;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-field inputs and pipeline-register controls between datapath and hazard controller.
interface pipeline_hazard_ctrl_if
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) ();

   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_use_rs;
   logic                  id_use_rt;
   logic [REG_ADDR_W-1:0] ex_rs;
   logic [REG_ADDR_W-1:0] ex_rt;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_mem_read;
   logic                  ex_branch_taken;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  mem_reg_write;
   logic                  wb_reg_write;
   logic                  mem_req;
   logic                  mem_ready;

   logic                  pc_en;
   logic                  pr1_en;
   logic                  pr1_flush;
   logic                  pr2_en;
   logic                  pr2_flush;
   logic                  pr3_en;
   logic                  pr4_bubble;
   fwd_sel_t              fwd_a;
   fwd_sel_t              fwd_b;
   logic                  halted;

   // Datapath side: supplies stage fields, consumes controls.
   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_rd,
             ex_mem_read, ex_branch_taken, mem_rd, wb_rd,
             mem_reg_write, wb_reg_write, mem_req, mem_ready,
      input  pc_en, pr1_en, pr1_flush, pr2_en, pr2_flush, pr3_en,
             pr4_bubble, fwd_a, fwd_b, halted
   );

   // Controller side.
   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_rd,
             ex_mem_read, ex_branch_taken, mem_rd, wb_rd,
             mem_reg_write, wb_reg_write, mem_req, mem_ready,
      output pc_en, pr1_en, pr1_flush, pr2_en, pr2_flush, pr3_en,
             pr4_bubble, fwd_a, fwd_b, halted
   );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for one EX source register; EX/MEM result beats MEM/WB.
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write,
   output fwd_sel_t              sel_c
);

   // r0 is never forwarded since it is hard-wired to zero.
   always_comb begin
      sel_c = FWD_RF;
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
         sel_c = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
         sel_c = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: stage enables/flushes, forwarding selects and memory-timeout halt.
// Optional perf counters (stall_cycles, flush_events) are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
   parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_hazard_ctrl_if.slave bus
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_events
`endif
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_stall;
   logic             load_use;
   fwd_sel_t         fwd_a_raw;
   fwd_sel_t         fwd_b_raw;

   assign mem_stall = bus.mem_req && !bus.mem_ready;

   assign load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                     ((bus.id_use_rs && (bus.ex_rd == bus.id_rs)) ||
                      (bus.id_use_rt && (bus.ex_rd == bus.id_rt)));

   hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .src          (bus.ex_rs),
      .mem_rd       (bus.mem_rd),
      .mem_reg_write(bus.mem_reg_write),
      .wb_rd        (bus.wb_rd),
      .wb_reg_write (bus.wb_reg_write),
      .sel_c        (fwd_a_raw)
   );

   hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .src          (bus.ex_rt),
      .mem_rd       (bus.mem_rd),
      .mem_reg_write(bus.mem_reg_write),
      .wb_rd        (bus.wb_rd),
      .wb_reg_write (bus.wb_reg_write),
      .sel_c        (fwd_b_raw)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus prioritised stage controls; everything held at pass-through while in reset.
   always_comb begin
      state_next     = state;
      bus.pc_en      = 1'b1;
      bus.pr1_en     = 1'b1;
      bus.pr1_flush  = 1'b0;
      bus.pr2_en     = 1'b1;
      bus.pr2_flush  = 1'b0;
      bus.pr3_en     = 1'b1;
      bus.pr4_bubble = 1'b0;
      bus.fwd_a      = FWD_RF;
      bus.fwd_b      = FWD_RF;

      case (state)
         ST_RUN: begin
            if (mem_stall) begin
               state_next = ST_MEM_WAIT;
            end
         end
         ST_MEM_WAIT: begin
            if (bus.mem_ready) begin
               state_next = ST_RUN;
            end else if (wait_cnt == TIMEOUT_LAST) begin
               state_next = ST_HALT;
            end
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase

      if (rst) begin
         bus.fwd_a = fwd_a_raw;
         bus.fwd_b = fwd_b_raw;
         if ((state == ST_HALT) || mem_stall) begin
            // Freeze everything up to EX/MEM; EX keeps its branch outcome for later.
            bus.pc_en      = 1'b0;
            bus.pr1_en     = 1'b0;
            bus.pr2_en     = 1'b0;
            bus.pr3_en     = 1'b0;
            bus.pr4_bubble = 1'b1;
         end else if (bus.ex_branch_taken) begin
            bus.pr1_flush = 1'b1;
            bus.pr2_flush = 1'b1;
         end else if (load_use) begin
            bus.pc_en     = 1'b0;
            bus.pr1_en    = 1'b0;
            bus.pr2_flush = 1'b1;
         end
      end
   end

   // Wait-cycle counter (counts the stall cycle that enters MEM_WAIT) and sticky halt flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt   <= '0;
         bus.halted <= 1'b0;
      end else begin
         if (state_next == ST_MEM_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         if (state_next == ST_HALT) begin
            bus.halted <= 1'b1;
         end
      end
   end

`ifdef PIPE_PERF_CNT_EN
   // Saturating counts of PC-stall cycles and IF/ID flush cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!bus.pc_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (bus.pr1_flush && (flush_events != '1)) begin
            flush_events <= flush_events + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (scoreboard of expected control vectors).
module tb_pipeline_hazard_ctrl;
   import hazard_pkg::*;

   localparam int unsigned RW    = 5;
   localparam int unsigned CNT_W = 16;

   typedef struct packed {
      logic          rst;
      logic [RW-1:0] id_rs;
      logic [RW-1:0] id_rt;
      logic          id_use_rs;
      logic          id_use_rt;
      logic [RW-1:0] ex_rs;
      logic [RW-1:0] ex_rt;
      logic [RW-1:0] ex_rd;
      logic          ex_mem_read;
      logic          ex_branch_taken;
      logic [RW-1:0] mem_rd;
      logic [RW-1:0] wb_rd;
      logic          mem_reg_write;
      logic          wb_reg_write;
      logic          mem_req;
      logic          mem_ready;
   } stim_t;

   typedef struct packed {
      logic       pc_en;
      logic       pr1_en;
      logic       pr1_flush;
      logic       pr2_en;
      logic       pr2_flush;
      logic       pr3_en;
      logic       pr4_bubble;
      logic [1:0] fwd_a;
      logic [1:0] fwd_b;
      logic       halted;
   } ctrl_t;

   localparam ctrl_t C_RUN = '{pc_en:1'b1, pr1_en:1'b1, pr1_flush:1'b0, pr2_en:1'b1,
      pr2_flush:1'b0, pr3_en:1'b1, pr4_bubble:1'b0, fwd_a:2'b00, fwd_b:2'b00, halted:1'b0};
   localparam ctrl_t C_STALL = '{pc_en:1'b0, pr1_en:1'b0, pr1_flush:1'b0, pr2_en:1'b0,
      pr2_flush:1'b0, pr3_en:1'b0, pr4_bubble:1'b1, fwd_a:2'b00, fwd_b:2'b00, halted:1'b0};
   localparam ctrl_t C_BR = '{pc_en:1'b1, pr1_en:1'b1, pr1_flush:1'b1, pr2_en:1'b1,
      pr2_flush:1'b1, pr3_en:1'b1, pr4_bubble:1'b0, fwd_a:2'b00, fwd_b:2'b00, halted:1'b0};
   localparam ctrl_t C_LU = '{pc_en:1'b0, pr1_en:1'b0, pr1_flush:1'b0, pr2_en:1'b1,
      pr2_flush:1'b1, pr3_en:1'b1, pr4_bubble:1'b0, fwd_a:2'b00, fwd_b:2'b00, halted:1'b0};

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   stim_t stim_q[$];
   ctrl_t exp_q[$];
   string name_q[$];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW)) bus ();

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;
`endif

   pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef PIPE_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
`endif
   );

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rst = 1'b1;
      s.mem_ready = 1'b1;
      return s;
   endfunction

   function automatic ctrl_t observe();
      ctrl_t o;
      o.pc_en      = bus.pc_en;
      o.pr1_en     = bus.pr1_en;
      o.pr1_flush  = bus.pr1_flush;
      o.pr2_en     = bus.pr2_en;
      o.pr2_flush  = bus.pr2_flush;
      o.pr3_en     = bus.pr3_en;
      o.pr4_bubble = bus.pr4_bubble;
      o.fwd_a      = bus.fwd_a;
      o.fwd_b      = bus.fwd_b;
      o.halted     = bus.halted;
      return o;
   endfunction

   task automatic apply(input stim_t s);
      rst                 = s.rst;
      bus.id_rs           = s.id_rs;
      bus.id_rt           = s.id_rt;
      bus.id_use_rs       = s.id_use_rs;
      bus.id_use_rt       = s.id_use_rt;
      bus.ex_rs           = s.ex_rs;
      bus.ex_rt           = s.ex_rt;
      bus.ex_rd           = s.ex_rd;
      bus.ex_mem_read     = s.ex_mem_read;
      bus.ex_branch_taken = s.ex_branch_taken;
      bus.mem_rd          = s.mem_rd;
      bus.wb_rd           = s.wb_rd;
      bus.mem_reg_write   = s.mem_reg_write;
      bus.wb_reg_write    = s.wb_reg_write;
      bus.mem_req         = s.mem_req;
      bus.mem_ready       = s.mem_ready;
   endtask

   task automatic add(input stim_t s, input ctrl_t e, input string n);
      stim_q.push_back(s);
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic test_reset();
      stim_t s;
      ctrl_t obs, e;
      string n;
      s = idle();
      s.rst = 1'b0; s.mem_req = 1'b1; s.mem_ready = 1'b0; s.ex_branch_taken = 1'b1;
      s.mem_reg_write = 1'b1; s.mem_rd = 5'd7; s.ex_rs = 5'd7;
      add(s, C_RUN, "reset_outputs_0");
      add(s, C_RUN, "reset_outputs_1");
      add(idle(), C_RUN, "after_reset");
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         #4;
         obs = observe(); e = exp_q.pop_front(); n = name_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            $display("FAIL %s: got %b expected %b", n, obs, e);
            n_fail++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_load_use();
      stim_t s;
      ctrl_t obs, e;
      string n;
      s = idle(); s.ex_mem_read = 1'b1; s.ex_rd = 5'd3; s.id_rs = 5'd3; s.id_use_rs = 1'b1;
      add(s, C_LU, "lu_rs_stall");
      s = idle(); s.mem_rd = 5'd3; s.mem_reg_write = 1'b1;
      add(s, C_RUN, "lu_bubble_cycle");
      s = idle(); s.ex_rs = 5'd3; s.wb_rd = 5'd3; s.wb_reg_write = 1'b1;
      e = C_RUN; e.fwd_a = FWD_WB;
      add(s, e, "lu_consumer_fwd_wb");
      s = idle(); s.ex_mem_read = 1'b1; s.ex_rd = 5'd9; s.id_rt = 5'd9; s.id_use_rt = 1'b1;
      add(s, C_LU, "lu_rt_stall");
      s.id_use_rt = 1'b0;
      add(s, C_RUN, "lu_rt_not_used");
      s = idle(); s.ex_mem_read = 1'b1; s.ex_rd = 5'd0; s.id_rs = 5'd0; s.id_use_rs = 1'b1;
      add(s, C_RUN, "lu_rd_zero");
      s = idle(); s.ex_rd = 5'd3; s.id_rs = 5'd3; s.id_use_rs = 1'b1;
      add(s, C_RUN, "lu_not_a_load");
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         #4;
         obs = observe(); e = exp_q.pop_front(); n = name_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            $display("FAIL %s: got %b expected %b", n, obs, e);
            n_fail++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      stim_t s;
      ctrl_t obs, e;
      string n;
      s = idle(); s.ex_branch_taken = 1'b1;
      s.ex_mem_read = 1'b1; s.ex_rd = 5'd3; s.id_rs = 5'd3; s.id_use_rs = 1'b1;
      add(s, C_BR, "branch_over_load_use");
      s = idle(); s.ex_branch_taken = 1'b1;
      add(s, C_BR, "branch_alone");
      s.mem_req = 1'b1; s.mem_ready = 1'b0;
      add(s, C_STALL, "branch_under_mem_stall");
      s.mem_ready = 1'b1;
      add(s, C_BR, "branch_after_release");
      add(idle(), C_RUN, "branch_idle");
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         #4;
         obs = observe(); e = exp_q.pop_front(); n = name_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            $display("FAIL %s: got %b expected %b", n, obs, e);
            n_fail++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mem_stall();
      stim_t s;
      ctrl_t obs, e;
      string n;
      s = idle(); s.mem_req = 1'b1; s.mem_ready = 1'b0;
      s.mem_rd = 5'd4; s.ex_rt = 5'd4; s.mem_reg_write = 1'b1;
      s.ex_mem_read = 1'b1; s.ex_rd = 5'd6; s.id_rs = 5'd6; s.id_use_rs = 1'b1;
      e = C_STALL; e.fwd_b = FWD_MEM;
      for (int i = 0; i < 3; i++) add(s, e, $sformatf("mem_wait_%0d", i));
      s.mem_ready = 1'b1; s.ex_mem_read = 1'b0;
      e = C_RUN; e.fwd_b = FWD_MEM;
      add(s, e, "mem_release_same_cycle");
      add(idle(), C_RUN, "mem_after_release");
      s = idle(); s.mem_req = 1'b1; s.mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) add(s, C_STALL, $sformatf("wait15_%0d", i));
      s.mem_ready = 1'b1;
      add(s, C_RUN, "wait15_release_no_halt");
      add(idle(), C_RUN, "wait15_idle");
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         #4;
         obs = observe(); e = exp_q.pop_front(); n = name_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            $display("FAIL %s: got %b expected %b", n, obs, e);
            n_fail++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_timeout();
      stim_t s;
      ctrl_t obs, e;
      string n;
      s = idle(); s.mem_req = 1'b1; s.mem_ready = 1'b0;
      for (int i = 1; i <= 16; i++) add(s, C_STALL, $sformatf("timeout_cycle_%0d", i));
      s.mem_ready = 1'b1;
      e = C_STALL; e.halted = 1'b1;
      add(s, e, "halt_cycle_17_ready");
      add(idle(), e, "halt_idle");
      s = idle(); s.ex_branch_taken = 1'b1; s.mem_reg_write = 1'b1; s.mem_rd = 5'd2; s.ex_rs = 5'd2;
      e.fwd_a = FWD_MEM;
      add(s, e, "halt_branch_ignored_fwd_live");
      s = idle(); s.rst = 1'b0;
      add(s, C_RUN, "halt_reset_clears");
      add(idle(), C_RUN, "halt_after_reset");
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         #4;
         obs = observe(); e = exp_q.pop_front(); n = name_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            $display("FAIL %s: got %b expected %b", n, obs, e);
            n_fail++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_forwarding();
      stim_t s;
      ctrl_t obs, e;
      string n;
      s = idle(); s.mem_rd = 5'd5; s.wb_rd = 5'd5; s.ex_rs = 5'd5;
      s.mem_reg_write = 1'b1; s.wb_reg_write = 1'b1;
      e = C_RUN; e.fwd_a = FWD_MEM;
      add(s, e, "fwd_a_mem_wins");
      s.mem_reg_write = 1'b0;
      e = C_RUN; e.fwd_a = FWD_WB;
      add(s, e, "fwd_a_wb");
      s.mem_reg_write = 1'b1; s.mem_rd = 5'd0; s.wb_rd = 5'd0; s.ex_rs = 5'd0;
      add(s, C_RUN, "fwd_a_r0");
      s = idle(); s.mem_rd = 5'd8; s.wb_rd = 5'd12; s.ex_rs = 5'd12; s.ex_rt = 5'd8;
      s.mem_reg_write = 1'b1; s.wb_reg_write = 1'b1;
      e = C_RUN; e.fwd_a = FWD_WB; e.fwd_b = FWD_MEM;
      add(s, e, "fwd_both_operands");
      s.wb_reg_write = 1'b0;
      e = C_RUN; e.fwd_b = FWD_MEM;
      add(s, e, "fwd_wb_disabled");
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         #4;
         obs = observe(); e = exp_q.pop_front(); n = name_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            $display("FAIL %s: got %b expected %b", n, obs, e);
            n_fail++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      stim_t s;
      ctrl_t obs, e;
      string n;
      s = idle(); s.ex_mem_read = 1'b1; s.ex_rd = 5'd10; s.id_rt = 5'd10; s.id_use_rt = 1'b1;
      add(s, C_LU, "b2b_lu");
      s = idle(); s.ex_branch_taken = 1'b1;
      add(s, C_BR, "b2b_branch");
      s = idle(); s.mem_req = 1'b1; s.mem_ready = 1'b0;
      add(s, C_STALL, "b2b_stall");
      s = idle(); s.mem_req = 1'b1; s.ex_mem_read = 1'b1; s.ex_rd = 5'd11; s.id_rs = 5'd11; s.id_use_rs = 1'b1;
      add(s, C_LU, "b2b_release_then_lu");
      add(idle(), C_RUN, "b2b_idle");
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         #4;
         obs = observe(); e = exp_q.pop_front(); n = name_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            $display("FAIL %s: got %b expected %b", n, obs, e);
            n_fail++;
         end
         @(negedge clk);
      end
   endtask

`ifdef PIPE_PERF_CNT_EN
   task automatic test_perf();
      stim_t s;
      s = idle(); s.rst = 1'b0;
      apply(s); @(negedge clk);
      s = idle(); s.ex_mem_read = 1'b1; s.ex_rd = 5'd3; s.id_rs = 5'd3; s.id_use_rs = 1'b1;
      apply(s); @(negedge clk);
      apply(s); @(negedge clk);
      s = idle(); s.ex_branch_taken = 1'b1;
      apply(s); @(negedge clk);
      apply(idle()); #4;
      n_checks++;
      if (stall_cycles !== CNT_W'(2)) begin
         $display("FAIL perf_stall_cycles: got %0d expected 2", stall_cycles);
         n_fail++;
      end
      n_checks++;
      if (flush_events !== CNT_W'(1)) begin
         $display("FAIL perf_flush_events: got %0d expected 1", flush_events);
         n_fail++;
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
      $fatal(1);
   end

   initial begin
      stim_t s;
      s = idle(); s.rst = 1'b0;
      apply(s);
      @(negedge clk);
      test_reset();
      test_load_use();
      test_branch();
      test_mem_stall();
      test_timeout();
      test_forwarding();
      test_back_to_back();
`ifdef PIPE_PERF_CNT_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
